// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses,
// interrupt cause codes, mstatus bit positions and the trap FSM states.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MIRQCFG  = 12'h7C0;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [4:0] CAUSE_MSI       = 5'd3;
    localparam logic [4:0] CAUSE_MTI       = 5'd7;
    localparam logic [4:0] CAUSE_MEI       = 5'd11;
    localparam logic [4:0] CAUSE_USER_BASE = 5'd16;

    // Machine interrupt enable/pending bits that exist regardless of channel count
    localparam logic [31:0] MACHINE_IRQ_MASK = 32'h0000_0888;

    typedef enum logic [1:0] {
        TRAP_IDLE,
        TRAP_REQ,
        TRAP_ENTRY
    } trap_state_t;

    // mip/mie bits 16.. occupied by the implemented user channels
    function automatic logic [31:0] user_irq_mask(input int count);
        return ((32'h1 << count) - 32'h1) << 16;
    endfunction

endpackage

// File: rtl/CSR_ConfigurationRegister.sv
// Plain read/write CSR with a write mask; masked-off bits hold 0 and read 0.
module CSR_ConfigurationRegister #(
    parameter logic [11:0] ADDRESS    = 12'h000,
    parameter logic [31:0] DEFAULT    = 32'h0,
    parameter logic [31:0] WRITE_MASK = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrWriteEnable,
    input  logic        csrReadEnable,
    input  logic [11:0] csrAddress,
    input  logic [31:0] csrWriteData,
    output logic [31:0] csrReadData,
    output logic        csrRequestOutput,
    output logic [31:0] value
);

    logic selected;
    assign selected = (csrAddress == ADDRESS);

    // Register update on an addressed write
    always_ff @(posedge clk) begin
        if (rst)
            value <= DEFAULT & WRITE_MASK;
        else if (csrWriteEnable && selected)
            value <= csrWriteData & WRITE_MASK;
    end

    assign csrRequestOutput = csrReadEnable && selected;
    assign csrReadData      = csrRequestOutput ? value : 32'h0;

endmodule

// File: rtl/trap_controller_irq_source.sv
// One user interrupt channel: synchroniser for the asynchronous line, rising
// edge detector and the edge-mode pending flop. In level mode the pending
// output simply mirrors the synchronised line.
module irq_source #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_line,
    input  logic edge_mode,
    input  logic clear,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_prev;
    logic                   edge_pend;
    logic                   synced;
    logic                   rise;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~synced_prev;

    // Synchroniser chain plus previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            synced_prev <= 1'b0;
        end else begin
            sync_q[0] <= irq_line;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
            synced_prev <= synced;
        end
    end

    // Edge pending: a fresh edge beats a same-cycle clear; dropped in level mode
    always_ff @(posedge clk) begin
        if (rst)
            edge_pend <= 1'b0;
        else if (edge_mode && rise)
            edge_pend <= 1'b1;
        else if (clear || !edge_mode)
            edge_pend <= 1'b0;
    end

    // The edge is visible in the same cycle the synced line is, so edge and
    // level channels share the same input-to-mip latency
    assign pending = edge_mode ? (edge_pend | rise) : synced;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap/interrupt CSR unit. Holds mstatus.MIE/MPIE, mie, mtvec,
// mscratch, mepc, mcause, mtval, mip and mirqcfg, prioritises interrupts and
// hands traps to the core through a REQ/ACCEPT handshake.
// Build option: define TRAP_VECTORED_EN to allow mtvec mode 01 (interrupts
// vector to base+4*cause); otherwise mtvec[1:0] is fixed at 00.
module trap_controller
    import trap_pkg::*;
#(
    parameter int USER_IRQ_COUNT = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      csrWriteEnable,
    input  logic                      csrReadEnable,
    input  logic [11:0]               csrAddress,
    input  logic [31:0]               csrWriteData,
    output logic [31:0]               csrReadData,
    output logic                      csrRequestOutput,
    input  logic [31:0]               programCounter,
    input  logic                      exceptionValid,
    input  logic [3:0]                exceptionCode,
    input  logic [31:0]               exceptionValue,
    input  logic                      msip,
    input  logic                      mtip,
    input  logic                      meip,
    input  logic [USER_IRQ_COUNT-1:0] userIrq,
    output logic                      trapRequest,
    input  logic                      trapAccept,
    input  logic                      trapReturn,
    output logic [31:0]               trapVector,
    output logic [31:0]               trapReturnVector
);

    localparam logic [31:0] MIE_MASK     = MACHINE_IRQ_MASK | user_irq_mask(USER_IRQ_COUNT);
    localparam logic [31:0] MIRQCFG_MASK = (32'h1 << USER_IRQ_COUNT) - 32'h1;

    trap_state_t state, next_state;

    logic        mie_q, mpie_q;
    logic [31:0] mtvec_q, mepc_q, mcause_q, mtval_q;

    logic        lat_irq;
    logic [4:0]  lat_cause;
    logic [31:0] lat_value, lat_pc;

    logic        load_en, load_irq;
    logic [4:0]  load_cause;
    logic [31:0] load_value, load_pc;
    logic        eff_irq;
    logic [4:0]  eff_cause;
    logic [31:0] eff_value, eff_pc;
    logic        commit;

    logic [31:0] mie_value, mscratch_value, mirqcfg_value;
    logic [31:0] mie_rd, mscratch_rd, mirqcfg_rd;
    logic        mie_req, mscratch_req, mirqcfg_req;

    logic [USER_IRQ_COUNT-1:0] user_pending;
    logic [31:0] mip, pend;
    logic        eligible;
    logic [4:0]  irq_cause;
    logic        wr_mip;

    logic        own_hit;
    logic [31:0] own_data;
    logic [31:0] vector;
    logic        unused_bits;

    CSR_ConfigurationRegister #(.ADDRESS(CSR_MIE), .WRITE_MASK(MIE_MASK)) mie_reg (
        .clk(clk), .rst(rst), .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
        .csrAddress(csrAddress), .csrWriteData(csrWriteData), .csrReadData(mie_rd),
        .csrRequestOutput(mie_req), .value(mie_value));

    CSR_ConfigurationRegister #(.ADDRESS(CSR_MSCRATCH)) mscratch_reg (
        .clk(clk), .rst(rst), .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
        .csrAddress(csrAddress), .csrWriteData(csrWriteData), .csrReadData(mscratch_rd),
        .csrRequestOutput(mscratch_req), .value(mscratch_value));

    CSR_ConfigurationRegister #(.ADDRESS(CSR_MIRQCFG), .WRITE_MASK(MIRQCFG_MASK)) mirqcfg_reg (
        .clk(clk), .rst(rst), .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
        .csrAddress(csrAddress), .csrWriteData(csrWriteData), .csrReadData(mirqcfg_rd),
        .csrRequestOutput(mirqcfg_req), .value(mirqcfg_value));

    // Masked-off upper mirqcfg bits are constant zero
    assign unused_bits = ^mirqcfg_value[31:USER_IRQ_COUNT];

    assign wr_mip = csrWriteEnable && (csrAddress == CSR_MIP);

    for (genvar i = 0; i < USER_IRQ_COUNT; i++) begin : g_user
        logic clear;
        assign clear = (wr_mip && !csrWriteData[16+i]) ||
                       (commit && eff_irq && eff_cause == CAUSE_USER_BASE + 5'(i));
        irq_source #(.SYNC_STAGES(SYNC_STAGES)) src (
            .clk(clk), .rst(rst), .irq_line(userIrq[i]), .edge_mode(mirqcfg_value[i]),
            .clear(clear), .pending(user_pending[i]));
    end

    // Assemble mip from the machine levels and the user channel pendings
    always_comb begin
        mip = '0;
        mip[3]  = msip;
        mip[7]  = mtip;
        mip[11] = meip;
        mip[16 +: USER_IRQ_COUNT] = user_pending;
    end

    assign pend     = mip & mie_value;
    assign eligible = mie_q && (|pend);

    // Fixed priority: MEI, MSI, MTI, then lowest user channel
    always_comb begin
        irq_cause = 5'd0;
        if (pend[11])
            irq_cause = CAUSE_MEI;
        else if (pend[3])
            irq_cause = CAUSE_MSI;
        else if (pend[7])
            irq_cause = CAUSE_MTI;
        else
            for (int i = USER_IRQ_COUNT - 1; i >= 0; i--)
                if (pend[16+i])
                    irq_cause = CAUSE_USER_BASE + 5'(i);
    end

    // Trap FSM next state and latch loading; an exception overrides a held interrupt
    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        load_irq   = 1'b0;
        load_cause = 5'd0;
        load_value = 32'h0;
        load_pc    = programCounter;
        unique case (state)
            TRAP_IDLE: begin
                if (exceptionValid) begin
                    load_en    = 1'b1;
                    load_cause = {1'b0, exceptionCode};
                    load_value = exceptionValue;
                    next_state = TRAP_REQ;
                end else if (eligible) begin
                    load_en    = 1'b1;
                    load_irq   = 1'b1;
                    load_cause = irq_cause;
                    next_state = TRAP_REQ;
                end
            end
            TRAP_REQ: begin
                if (exceptionValid && lat_irq) begin
                    load_en    = 1'b1;
                    load_cause = {1'b0, exceptionCode};
                    load_value = exceptionValue;
                end
                if (trapAccept)
                    next_state = TRAP_ENTRY;
            end
            TRAP_ENTRY: next_state = TRAP_IDLE;
            default:    next_state = TRAP_IDLE;
        endcase
    end

    assign eff_irq   = load_en ? load_irq   : lat_irq;
    assign eff_cause = load_en ? load_cause : lat_cause;
    assign eff_value = load_en ? load_value : lat_value;
    assign eff_pc    = load_en ? load_pc    : lat_pc;
    assign commit    = (state == TRAP_REQ) && trapAccept;

    // FSM state and the pending-trap latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TRAP_IDLE;
            lat_irq   <= 1'b0;
            lat_cause <= 5'd0;
            lat_value <= 32'h0;
            lat_pc    <= 32'h0;
        end else begin
            state <= next_state;
            if (load_en) begin
                lat_irq   <= load_irq;
                lat_cause <= load_cause;
                lat_value <= load_value;
                lat_pc    <= load_pc;
            end
        end
    end

    // Software CSR writes first; trap commit and MRET come later so they win
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= 32'h0;
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
            mtval_q  <= 32'h0;
        end else begin
            if (csrWriteEnable) begin
                unique case (csrAddress)
                    CSR_MSTATUS: begin
                        mie_q  <= csrWriteData[MSTATUS_MIE];
                        mpie_q <= csrWriteData[MSTATUS_MPIE];
                    end
`ifdef TRAP_VECTORED_EN
                    CSR_MTVEC:  mtvec_q <= {csrWriteData[31:2], 1'b0, csrWriteData[1:0] == 2'b01};
`else
                    CSR_MTVEC:  mtvec_q <= {csrWriteData[31:2], 2'b00};
`endif
                    CSR_MEPC:   mepc_q   <= {csrWriteData[31:1], 1'b0};
                    CSR_MCAUSE: mcause_q <= csrWriteData;
                    CSR_MTVAL:  mtval_q  <= csrWriteData;
                    default: ;
                endcase
            end
            if (commit) begin
                mepc_q   <= eff_pc;
                mcause_q <= {eff_irq, 26'b0, eff_cause};
                mtval_q  <= eff_value;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (state == TRAP_IDLE && trapReturn) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end
    end

    // Read mux for the registers held directly in this module
    always_comb begin
        own_hit  = 1'b1;
        own_data = 32'h0;
        unique case (csrAddress)
            CSR_MSTATUS: own_data = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
            CSR_MTVEC:   own_data = mtvec_q;
            CSR_MEPC:    own_data = mepc_q;
            CSR_MCAUSE:  own_data = mcause_q;
            CSR_MTVAL:   own_data = mtval_q;
            CSR_MIP:     own_data = mip;
            default:     own_hit  = 1'b0;
        endcase
    end

    assign csrRequestOutput = (csrReadEnable && own_hit) || mie_req || mscratch_req || mirqcfg_req;
    assign csrReadData      = ((csrReadEnable && own_hit) ? own_data : 32'h0) |
                              mie_rd | mscratch_rd | mirqcfg_rd;

    // Handler address from the committed mcause; only driven during ENTRY
    always_comb begin
        vector = {mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (mtvec_q[0] && mcause_q[31])
            vector = {mtvec_q[31:2], 2'b00} + {25'b0, mcause_q[4:0], 2'b00};
`endif
    end

    assign trapRequest      = (state == TRAP_REQ);
    assign trapVector       = (state == TRAP_ENTRY) ? vector : 32'h0;
    assign trapReturnVector = {mepc_q[31:1], 1'b0};

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: expected values are queued when the
// stimulus is applied and popped when the matching DUT output is sampled.
module tb_trap_controller;

    localparam int N    = 16;
    localparam int SYNC = 2;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] MTVEC_EXP   = 32'h0000_1001;
    localparam logic [31:0] VEC_MTI_EXP = 32'h0000_101C;
    localparam logic [31:0] VEC_MSI_EXP = 32'h0000_100C;
`else
    localparam logic [31:0] MTVEC_EXP   = 32'h0000_1000;
    localparam logic [31:0] VEC_MTI_EXP = 32'h0000_1000;
    localparam logic [31:0] VEC_MSI_EXP = 32'h0000_1000;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          csrWriteEnable, csrReadEnable;
    logic [11:0]   csrAddress;
    logic [31:0]   csrWriteData, csrReadData;
    logic          csrRequestOutput;
    logic [31:0]   programCounter;
    logic          exceptionValid;
    logic [3:0]    exceptionCode;
    logic [31:0]   exceptionValue;
    logic          msip, mtip, meip;
    logic [N-1:0]  userIrq;
    logic          trapRequest, trapAccept, trapReturn;
    logic [31:0]   trapVector, trapReturnVector;

    always #5 clk = ~clk;

    trap_controller #(.USER_IRQ_COUNT(N), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
        .csrAddress(csrAddress), .csrWriteData(csrWriteData),
        .csrReadData(csrReadData), .csrRequestOutput(csrRequestOutput),
        .programCounter(programCounter), .exceptionValid(exceptionValid),
        .exceptionCode(exceptionCode), .exceptionValue(exceptionValue),
        .msip(msip), .mtip(mtip), .meip(meip), .userIrq(userIrq),
        .trapRequest(trapRequest), .trapAccept(trapAccept), .trapReturn(trapReturn),
        .trapVector(trapVector), .trapReturnVector(trapReturnVector));

    logic [31:0] exp_q[$];
    int passed = 0;
    int total  = 0;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            assert (0) else $error("FAIL %s: no expected value queued, observed 0x%08h", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(e);
        check(tag, obs);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csrWriteEnable = 1'b1;
        csrAddress     = a;
        csrWriteData   = d;
        tick();
        csrWriteEnable = 1'b0;
    endtask

    task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] e);
        expect_val(e);
        csrReadEnable = 1'b1;
        csrAddress    = a;
        #1;
        check(tag, csrReadData);
        csrReadEnable = 1'b0;
    endtask

    task automatic accept_trap();
        trapAccept = 1'b1;
        tick();
        trapAccept = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] rst_addrs [9];
        rst_addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                      12'h342, 12'h343, 12'h344, 12'h7C0};

        rst = 1'b1;
        csrWriteEnable = 1'b0; csrReadEnable = 1'b0;
        csrAddress = '0; csrWriteData = '0;
        programCounter = '0;
        exceptionValid = 1'b0; exceptionCode = '0; exceptionValue = '0;
        msip = 1'b0; mtip = 1'b0; meip = 1'b0; userIrq = '0;
        trapAccept = 1'b0; trapReturn = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("rst_trapRequest", {31'b0, trapRequest}, 32'h0);
        chk("rst_trapVector", trapVector, 32'h0);
        for (int i = 0; i < 9; i++)
            csr_rd($sformatf("rst_csr_%03h", rst_addrs[i]), rst_addrs[i], 32'h0);

        // Address decode of the request strobe
        csrReadEnable = 1'b1;
        csrAddress = 12'h341; #1;
        chk("req_owned", {31'b0, csrRequestOutput}, 32'h1);
        csrAddress = 12'h301; #1;
        chk("req_unowned", {31'b0, csrRequestOutput}, 32'h0);
        chk("rd_unowned", csrReadData, 32'h0);
        csrReadEnable = 1'b0;

        // WARL and masked registers
        csr_wr(12'h305, 32'h0000_1001);
        csr_rd("mtvec_mode", 12'h305, MTVEC_EXP);
        csr_wr(12'h340, 32'hA5A5_5A5A);
        csr_rd("mscratch", 12'h340, 32'hA5A5_5A5A);
        csr_wr(12'h7C0, 32'hFFFF_FFFF);
        csr_rd("mirqcfg_mask", 12'h7C0, 32'h0000_FFFF);
        csr_wr(12'h7C0, 32'h0);
        csr_wr(12'h304, 32'hFFFF_FFFF);
        csr_rd("mie_mask", 12'h304, 32'hFFFF_0888);
        csr_wr(12'h341, 32'h0000_2003);
        csr_rd("mepc_bit0", 12'h341, 32'h0000_2002);
        chk("retvec_write", trapReturnVector, 32'h0000_2002);

        // Timer interrupt taken and returned from
        csr_wr(12'h304, 32'h0000_0080);
        programCounter = 32'h200;
        mtip = 1'b1;
        csr_wr(12'h300, 32'h8);
        tick();
        chk("mti_request", {31'b0, trapRequest}, 32'h1);
        accept_trap();
        chk("mti_entry_req", {31'b0, trapRequest}, 32'h0);
        chk("mti_vector", trapVector, VEC_MTI_EXP);
        csr_rd("mti_mepc", 12'h341, 32'h200);
        csr_rd("mti_mcause", 12'h342, 32'h8000_0007);
        csr_rd("mti_mstatus", 12'h300, 32'h80);
        csr_rd("mti_mtval", 12'h343, 32'h0);
        tick();
        mtip = 1'b0;
        trapReturn = 1'b1;
        tick();
        trapReturn = 1'b0;
        csr_rd("mret_mstatus", 12'h300, 32'h88);
        chk("mret_vector", trapReturnVector, 32'h200);

        // Edge-mode user channel 2: one-cycle pulse, request latency
        csr_wr(12'h7C0, 32'h4);
        csr_wr(12'h304, 32'h0004_0000);
        programCounter = 32'h300;
        userIrq[2] = 1'b1;
        expect_val(32'h0);
        expect_val(32'h1);
        tick();
        userIrq[2] = 1'b0;
        tick(SYNC - 1);
        check("edge_lat_early", {31'b0, trapRequest});
        tick();
        check("edge_lat_req", {31'b0, trapRequest});
        csr_rd("edge_mip_held", 12'h344, 32'h0004_0000);
        accept_trap();
        csr_rd("edge_mcause", 12'h342, 32'h8000_0012);
        csr_rd("edge_mip_clr", 12'h344, 32'h0);
        csr_rd("edge_mepc", 12'h341, 32'h300);
        tick();

        // Priority MEI over level user channel 0, then exception override
        csr_wr(12'h304, 32'h0001_0800);
        meip = 1'b1;
        userIrq[0] = 1'b1;
        programCounter = 32'h400;
        tick(SYNC + 1);
        csr_rd("level_mip", 12'h344, 32'h0001_0800);
        csr_wr(12'h300, 32'h8);
        tick();
        chk("mei_request", {31'b0, trapRequest}, 32'h1);
        accept_trap();
        csr_rd("mei_mcause", 12'h342, 32'h8000_000B);
        csr_rd("mei_mepc", 12'h341, 32'h400);
        tick();
        csr_wr(12'h300, 32'h8);
        tick();
        chk("ovr_request", {31'b0, trapRequest}, 32'h1);
        exceptionValid = 1'b1;
        exceptionCode  = 4'd2;
        exceptionValue = 32'h0000_0BAD;
        programCounter = 32'h404;
        tick();
        exceptionValid = 1'b0;
        chk("ovr_held", {31'b0, trapRequest}, 32'h1);
        accept_trap();
        csr_rd("ovr_mcause", 12'h342, 32'h2);
        csr_rd("ovr_mtval", 12'h343, 32'h0000_0BAD);
        csr_rd("ovr_mepc", 12'h341, 32'h404);
        tick();

        // Software interrupt vector, then exception to base
        meip = 1'b0;
        userIrq = '0;
        tick(SYNC + 1);
        csr_wr(12'h304, 32'h8);
        msip = 1'b1;
        csr_wr(12'h305, 32'h0000_1001);
        csr_wr(12'h300, 32'h8);
        tick();
        chk("msi_request", {31'b0, trapRequest}, 32'h1);
        accept_trap();
        chk("msi_vector", trapVector, VEC_MSI_EXP);
        csr_rd("msi_mcause", 12'h342, 32'h8000_0003);
        tick();
        msip = 1'b0;
        exceptionValid = 1'b1;
        exceptionCode  = 4'd11;
        exceptionValue = 32'h0;
        tick();
        exceptionValid = 1'b0;
        chk("exc_request", {31'b0, trapRequest}, 32'h1);
        accept_trap();
        chk("exc_vector", trapVector, 32'h0000_1000);
        csr_rd("exc_mcause", 12'h342, 32'hB);
        tick();

        // Reset while a request is pending
        exceptionValid = 1'b1;
        exceptionCode  = 4'd5;
        tick();
        exceptionValid = 1'b0;
        chk("rstreq_pending", {31'b0, trapRequest}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstreq_dropped", {31'b0, trapRequest}, 32'h0);
        csr_rd("rstreq_mepc", 12'h341, 32'h0);
        csr_rd("rstreq_mstatus", 12'h300, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
